// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b mod 2^L
module serial_subtractor #(
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [L-1:0] diff,
    output logic         ovf
);

    localparam int CW = (L > 2) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [L-1:0]  r_ra;
    logic [L-1:0]  r_rb;
    logic [L-1:0]  r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_sa;
    logic          r_sb;

    logic          w_sum;
    logic          w_carry;
    logic [L-1:0]  w_rd_next;

    // Single full-adder cell: subtrahend already inverted, carry preset to 1.
    always_comb begin
        w_sum     = r_ra[0] ^ r_rb[0] ^ r_carry;
        w_carry   = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
        w_rd_next = {w_sum, r_rd[L-1:1]};
    end

    // Control FSM and datapath; every output is a flop so none depends combinationally on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= ~b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_sa    <= a[L-1];
                        r_sb    <= b[L-1];
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_carry <= w_carry;
                    r_rd    <= w_rd_next;
                    r_ra    <= r_ra >> 1;
                    r_rb    <= r_rb >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Overflow only possible when operand signs differ; then the
                        // result sign must follow the minuend.
                        diff    <= w_rd_next;
                        ovf     <= (r_sa != r_sb) && (w_sum != r_sa);
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
